// File: rtl/riscv_types_pkg.sv
// Shared RISC-V load types, the load_unit state encoding and funct3 decode helpers.
package riscv_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } load_state_e;

  function automatic logic load_fun3_legal(input logic [2:0] fun3);
    logic legal;
    case (fun3)
      LB, LH, LW, LBU, LHU: legal = 1'b1;
      default:              legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic load_misaligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
    logic mis;
    case (fun3)
      LH, LHU: mis = addr_lo[0];
      LW:      mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a read word for RISC-V loads.
module load_align
  import riscv_types::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  fun3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    unique case (addr_lo_i)
      2'b00: byte_lane = word_i[7:0];
      2'b01: byte_lane = word_i[15:8];
      2'b10: byte_lane = word_i[23:16];
      2'b11: byte_lane = word_i[31:24];
      default: byte_lane = word_i[7:0];
    endcase
    half_lane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (fun3_i)
      LB:      data_o = {{24{byte_lane[7]}}, byte_lane};
      LH:      data_o = {{16{half_lane[15]}}, half_lane};
      LW:      data_o = word_i;
      LBU:     data_o = {24'b0, byte_lane};
      LHU:     data_o = {16'b0, half_lane};
      default: data_o = 32'b0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: IDLE/REQ/WAIT/RESP handshake with a WAIT watchdog.
// Optional MISALIGNED_TRAP_EN traps misaligned LH/LHU/LW without touching the bus.
module load_unit
  import riscv_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_fun3,
  input  logic [4:0]  ld_rd,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [31:0] ld_rdata,
  output logic [4:0]  ld_rd_o,
  output logic        ld_fault,
  output logic        ld_misaligned,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam logic [31:0] WdLast = 32'(TIMEOUT_CYCLES - 1);

  load_state_e state_q, state_d;

  logic [31:0] addr_q;
  logic [2:0]  fun3_q;
  logic [4:0]  rd_q;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        fault_q, fault_d;
  logic [31:0] aligned;
  logic        accept, trap_mis, skip_bus, wd_hit, wait_done;

`ifdef MISALIGNED_TRAP_EN
  logic mis_q, mis_d;
  assign trap_mis = load_misaligned(ld_fun3, ld_addr[1:0]);
`else
  assign trap_mis = 1'b0;
`endif

  assign accept    = (state_q == StIdle) && ld_valid;
  assign skip_bus  = !load_fun3_legal(ld_fun3) || trap_mis;
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && (wd_q == WdLast);
  assign wait_done = bus_rvalid || bus_err || wd_hit;

  load_align u_align (
    .word_i    (bus_rdata),
    .addr_lo_i (addr_q[1:0]),
    .fun3_i    (fun3_q),
    .data_o    (aligned)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ld_valid) state_d = skip_bus ? StResp : StReq;
      StReq:   if (bus_gnt) state_d = StWait;
      StWait:  if (wait_done) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; busy is gated by reset so it reads 0 while reset is held
  always_comb begin
    ld_busy  = !reset && (accept || (state_q == StReq) || (state_q == StWait));
    bus_req  = (state_q == StReq);
    ld_done  = (state_q == StResp);
    bus_addr = {addr_q[31:2], 2'b00};
  end

  // Result registers only change on the way into RESP, so they hold between loads.
  always_comb begin
    rdata_d  = rdata_q;
    rd_out_d = rd_out_q;
    fault_d  = fault_q;
    wd_d     = (state_q == StWait) ? wd_q + 32'd1 : 32'd0;
`ifdef MISALIGNED_TRAP_EN
    mis_d    = mis_q;
`endif
    if (accept && skip_bus) begin
      rdata_d  = 32'b0;
      rd_out_d = ld_rd;
      fault_d  = 1'b1;
`ifdef MISALIGNED_TRAP_EN
      mis_d    = trap_mis;
`endif
    end else if ((state_q == StWait) && wait_done) begin
      rd_out_d = rd_q;
`ifdef MISALIGNED_TRAP_EN
      mis_d    = 1'b0;
`endif
      // Error wins over a simultaneous rvalid; timeout has neither.
      if (bus_err || !bus_rvalid) begin
        rdata_d = 32'b0;
        fault_d = 1'b1;
      end else begin
        rdata_d = aligned;
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= 32'b0;
      fun3_q   <= 3'b0;
      rd_q     <= 5'b0;
      wd_q     <= 32'b0;
      rdata_q  <= 32'b0;
      rd_out_q <= 5'b0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= ld_addr;
        fun3_q <= ld_fun3;
        rd_q   <= ld_rd;
      end
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      rd_out_q <= rd_out_d;
      fault_q  <= fault_d;
    end
  end

`ifdef MISALIGNED_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
  assign ld_misaligned = mis_q;
`else
  assign ld_misaligned = 1'b0;
`endif

  assign ld_rdata = rdata_q;
  assign ld_rd_o  = rd_out_q;
  assign ld_fault = fault_q;

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the WAIT-state watchdog limit in cycles; 0 disables the watchdog.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ld_valid  in  1  load request from the EX/MEM stage.
REQ-005 SHALL have port ld_addr  in  32  byte address.
REQ-006 SHALL have port ld_fun3  in  3  load type (RISC-V funct3).
REQ-007 SHALL have port ld_rd  in  5  destination register.
REQ-008 SHALL have port ld_busy  out  1  pipeline stall request.
REQ-009 SHALL have port ld_done  out  1  one-cycle result strobe.
REQ-010 SHALL have port ld_rdata  out  32  aligned and extended load data.
REQ-011 SHALL have port ld_rd_o  out  5  captured destination register.
REQ-012 SHALL have port ld_fault  out  1  bus error, timeout or illegal funct3, valid with ld_done.
REQ-013 SHALL have port ld_misaligned  out  1  misaligned-access flag, valid with ld_done.
REQ-014 SHALL have port bus_req  out  1  read request to data memory.
REQ-015 SHALL have port bus_addr  out  32  word-aligned address, with bits [1:0] = 0.
REQ-016 SHALL have port bus_gnt  in  1  request accepted.
REQ-017 SHALL have port bus_rvalid  in  1  read data valid.
REQ-018 SHALL have port bus_rdata  in  32  read data.
REQ-019 SHALL have port bus_err  in  1  read error response.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-021 In IDLE with ld_valid=1, SHALL capture addr/fun3/rd and go to REQ; ld_valid SHALL be ignored outside IDLE.
REQ-022 REQ SHALL assert bus_req and hold bus_addr stable until bus_gnt=1, then go to WAIT; rvalid/err in REQ SHALL be ignored.
REQ-023 WAIT SHALL go to RESP on bus_rvalid=1, on bus_err=1, or when the watchdog count reaches TIMEOUT_CYCLES (when TIMEOUT_CYCLES != 0).
REQ-024 The watchdog counter SHALL clear on entry to WAIT and increment once per WAIT cycle.
REQ-025 If bus_rvalid=1 and bus_err=1 occur together, the error SHALL take priority: ld_fault=1 and ld_rdata=0.
REQ-026 A timeout SHALL set ld_fault=1 and ld_rdata=0; a bus_rvalid arriving after RESP SHALL be ignored.
REQ-027 RESP SHALL last exactly one cycle with ld_done=1, then go to IDLE.
REQ-028 ld_rdata, ld_rd_o, ld_fault and ld_misaligned SHALL be registered and SHALL hold their values until the next RESP.
REQ-029 ld_busy SHALL equal (IDLE & ld_valid) | REQ | WAIT, and SHALL be low in RESP.
REQ-030 Minimum latency SHALL be 3 cycles: accept at t0, gnt at t1, rvalid at t2, ld_done at t3.
REQ-031 Byte loads SHALL select lane addr[1:0]; halfword loads SHALL select lane addr[1]; word loads SHALL pass the full word.
REQ-032 fun3 000/001 (LB/LH) SHALL sign-extend, 100/101 (LBU/LHU) SHALL zero-extend, and 010 (LW) SHALL pass through.
REQ-033 fun3 011/110/111 SHALL issue no bus access and go IDLE->RESP with ld_fault=1 and ld_rdata=0.

Reset
REQ-034 reset SHALL asynchronously force IDLE, clear the watchdog, and drive every output to 0, including mid-transaction.
REQ-035 No ld_done SHALL be generated for a transaction aborted by reset.

Configuration
REQ-036 With MISALIGNED_TRAP_EN defined, LH/LHU with addr[0]=1 or LW with addr[1:0]!=0 SHALL skip the bus and go IDLE->RESP with ld_fault=1, ld_misaligned=1 and ld_rdata=0.
REQ-037 Without MISALIGNED_TRAP_EN, ld_misaligned SHALL be tied to 0 and low address bits not used by REQ-031 SHALL be ignored.

Structure
REQ-038 Package riscv_types SHALL gain load_t (LB=000, LH=001, LW=010, LBU=100, LHU=101) and the load_unit state enum.
REQ-039 Lane selection and extension SHALL be a combinational sub-module load_align.

Verification
REQ-040 LB addr 0x1003, gnt t1, rvalid t2, rdata 0x80112233 -> ld_done at t3, ld_rdata 0xFFFFFF80.
REQ-041 LHU addr 0x2002, rdata 0xBEEF1234, gnt held low 4 cycles -> bus_req stays high and bus_addr stays 0x2000 throughout; ld_rdata 0x0000BEEF.
REQ-042 LW with bus_rvalid=1 and bus_err=1 in the same cycle -> ld_fault=1, ld_rdata=0; with TIMEOUT_CYCLES=4 and no response -> ld_done 4 cycles after entering WAIT with ld_fault=1.
REQ-043 reset pulse during WAIT -> bus_req=0 and ld_busy=0 immediately, no ld_done; a following LW completes normally.
REQ-044 LW addr 0x1002 with MISALIGNED_TRAP_EN -> no bus_req, ld_done on the next cycle with ld_misaligned=1; without the macro -> normal read of 0x1000.
REQ-045 fun3=111 -> no bus_req, ld_fault=1 one cycle after accept.
